// File: rtl/partitioned_multiport_ram.sv
// Multi-port register-file RAM split into 4 partitions that self-initialises after reset.
// Optional macro RAM_PARTITION_GATING_EN enables per-partition power gating.
module partitioned_multiport_ram #(
  parameter int unsigned DEPTH        = 64,
  parameter int unsigned INDEX        = 6,
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned NUM_RD_PORTS = 4,
  parameter int unsigned NUM_WR_PORTS = 2,
  parameter int unsigned WR_PORTS_LOG = 1,
  parameter int unsigned RESET_VAL    = 0,
  parameter int unsigned SEQ_START    = 0
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [NUM_WR_PORTS-1:0]                writePortGated_i,
  input  logic [NUM_RD_PORTS-1:0]                readPortGated_i,
  input  logic [3:0]                             partitionGated_i,
  input  logic [NUM_RD_PORTS-1:0][INDEX-1:0]     addr_i,
  output logic [NUM_RD_PORTS-1:0][WIDTH-1:0]     data_o,
  input  logic [NUM_WR_PORTS-1:0][INDEX-1:0]     addrWr_i,
  input  logic [NUM_WR_PORTS-1:0][WIDTH-1:0]     dataWr_i,
  input  logic [NUM_WR_PORTS-1:0]                wrEn_i,
  output logic                                   ramReady_o
);

  localparam int unsigned PTR_W = INDEX + 1;

  typedef enum logic {ST_INIT, ST_READY} state_t;

  state_t                              state_q, state_d;
  logic [PTR_W-1:0]                    ptr_q, ptr_d, ptr_next;
  logic                                sweep_en;
  logic [3:0]                          part_active;
  logic [NUM_WR_PORTS-1:0]             wr_ok;
  logic [NUM_WR_PORTS-1:0][PTR_W-1:0]  sweep_idx;
  logic [WIDTH-1:0]                    mem [DEPTH];
  logic                                unused_cfg;

  function automatic logic in_range(input logic [INDEX-1:0] a);
    return {1'b0, a} < PTR_W'(DEPTH);
  endfunction

  function automatic logic accessible(input logic [INDEX-1:0] a, input logic [3:0] act);
    return in_range(a) && act[a[INDEX-1:INDEX-2]];
  endfunction

  function automatic logic [WIDTH-1:0] init_val(input logic [PTR_W-1:0] idx);
    return (RESET_VAL == 1) ? WIDTH'(SEQ_START) + WIDTH'(idx) : '0;
  endfunction

`ifdef RAM_PARTITION_GATING_EN
  assign part_active = ~partitionGated_i;
`else
  assign part_active = 4'hF;
`endif

  assign unused_cfg = ^{1'b0, partitionGated_i, WR_PORTS_LOG[0]};

  // Init sweep state register; the pointer restarts from entry 0 on every reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_INIT;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  assign ptr_next = ptr_q + PTR_W'(NUM_WR_PORTS);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_INIT: begin
        if (ptr_next >= PTR_W'(DEPTH)) state_d = ST_READY;
        else                           ptr_d   = ptr_next;
      end
      ST_READY: state_d = ST_READY;
      default:  state_d = ST_INIT;
    endcase
  end

  always_comb begin
    sweep_en   = (state_q == ST_INIT);
    ramReady_o = (state_q == ST_READY);
  end

  always_comb begin
    for (int unsigned w = 0; w < NUM_WR_PORTS; w++) begin
      sweep_idx[w] = ptr_q + PTR_W'(w);
      wr_ok[w]     = ramReady_o && wrEn_i[w] && !writePortGated_i[w] &&
                     accessible(addrWr_i[w], part_active);
    end
  end

  // Later ports overwrite earlier ones, so the highest-indexed port wins a collision
  always_ff @(posedge clk) begin
    for (int unsigned w = 0; w < NUM_WR_PORTS; w++) begin
      if (sweep_en && (sweep_idx[w] < PTR_W'(DEPTH)))
        mem[sweep_idx[w][INDEX-1:0]] <= init_val(sweep_idx[w]);
      else if (wr_ok[w])
        mem[addrWr_i[w]] <= dataWr_i[w];
    end
  end

  // Combinational reads with no write bypass
  always_comb begin
    for (int unsigned i = 0; i < NUM_RD_PORTS; i++) begin
      data_o[i] = '0;
      if (!readPortGated_i[i] && accessible(addr_i[i], part_active))
        data_o[i] = mem[addr_i[i]];
    end
  end

endmodule

// File: tb/tb_partitioned_multiport_ram.sv
// Directed bench for partitioned_multiport_ram: init sweep, port/partition gating, collisions, random traffic.
module tb_partitioned_multiport_ram;

  logic            clk;
  logic            reset;
  logic [1:0]      wpg;
  logic [3:0]      rpg;
  logic [3:0]      pg;
  logic [3:0][5:0] addr;
  logic [1:0][5:0] addr_wr;
  logic [1:0][31:0] data_wr;
  logic [1:0]      wr_en;
  logic [3:0][31:0] rd_z;
  logic [3:0][31:0] rd_s;
  logic            ready_z;
  logic            ready_s;

  int errors = 0;
  int checks = 0;

  partitioned_multiport_ram u_zero (
    .clk(clk), .reset(reset),
    .writePortGated_i(wpg), .readPortGated_i(rpg), .partitionGated_i(pg),
    .addr_i(addr), .data_o(rd_z),
    .addrWr_i(addr_wr), .dataWr_i(data_wr), .wrEn_i(wr_en),
    .ramReady_o(ready_z)
  );

  partitioned_multiport_ram #(.RESET_VAL(1), .SEQ_START(0)) u_seq (
    .clk(clk), .reset(reset),
    .writePortGated_i(wpg), .readPortGated_i(rpg), .partitionGated_i(pg),
    .addr_i(addr), .data_o(rd_s),
    .addrWr_i(addr_wr), .dataWr_i(data_wr), .wrEn_i(wr_en),
    .ramReady_o(ready_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] mdl [16];
    logic [31:0] exp_gated;
    logic [31:0] exp_ungated;
    int cnt;
    int err_before;

    reset = 1'b0; wpg = '0; rpg = '0; pg = '0;
    addr = '0; addr_wr = '0; data_wr = '0; wr_en = '0;

    // Reset held for 5 cycles, then full sweep of 32 cycles
    repeat (3) tick();
    check("rst_ready", 32'(ready_z), 32'd0);
    repeat (2) tick();
    reset = 1'b1;
    cnt = 0;
    while (!ready_z && cnt < 200) begin tick(); cnt++; end
    check("init_cycles", 32'(cnt), 32'd32);
    check("seq_ready", 32'(ready_s), 32'd1);

    // Reset mid-sweep aborts, restart from 0 takes another full sweep
    reset = 1'b0; tick(); reset = 1'b1;
    repeat (10) tick();
    check("mid_sweep_ready", 32'(ready_z), 32'd0);
    reset = 1'b0; #1;
    check("abort_ready", 32'(ready_z), 32'd0);
    tick(); reset = 1'b1;
    cnt = 0;
    while (!ready_z && cnt < 200) begin tick(); cnt++; end
    check("restart_cycles", 32'(cnt), 32'd32);

    // Every entry zero in the ZERO instance and k in the SEQ instance
    for (int a = 0; a < 64; a += 4) begin
      for (int p = 0; p < 4; p++) addr[p] = 6'(a + p);
      #1;
      for (int p = 0; p < 4; p++) begin
        check("zero_init", rd_z[p], 32'd0);
        check("seq_init", rd_s[p], 32'(a + p));
      end
    end
    addr[0] = 6'h05; addr[1] = 6'h3F; #1;
    check("seq_05", rd_s[0], 32'h05);
    check("seq_3f", rd_s[1], 32'h3F);

    // Same-cycle read sees old value, next cycle sees new
    addr_wr[0] = 6'h03; data_wr[0] = 32'hDEADBEEF; wr_en = 2'b01; addr[0] = 6'h03; #1;
    check("same_cycle_old", rd_z[0], 32'd0);
    tick(); wr_en = '0; #1;
    check("next_cycle_new", rd_z[0], 32'hDEADBEEF);

    // Write collision: higher port wins
    addr_wr[0] = 6'h07; addr_wr[1] = 6'h07; data_wr[0] = 32'h11; data_wr[1] = 32'h22; wr_en = 2'b11;
    tick(); wr_en = '0; addr[1] = 6'h07; #1;
    check("wr_conflict", rd_z[1], 32'h22);
    wpg = 2'b01; data_wr[0] = 32'h33; wr_en = 2'b01;
    tick(); wr_en = '0; wpg = '0; #1;
    check("wr_port0_gated", rd_z[1], 32'h22);
    wpg = 2'b10; data_wr[0] = 32'h44; data_wr[1] = 32'h55; wr_en = 2'b11;
    tick(); wr_en = '0; wpg = '0; #1;
    check("wr_port1_gated", rd_z[1], 32'h44);

    // Read-port gating
    rpg = 4'b0100; addr[2] = 6'h03; addr[3] = 6'h03; #1;
    check("rd_port_gated", rd_z[2], 32'd0);
    check("rd_port_open", rd_z[3], 32'hDEADBEEF);
    rpg = '0;

    // Partition gating (effective only when the macro is defined)
    addr_wr[0] = 6'h20; data_wr[0] = 32'hA5A5A5A5; wr_en = 2'b01;
    tick(); wr_en = '0;
    pg = 4'b1110;
    addr_wr[0] = 6'h20; data_wr[0] = 32'h55; addr_wr[1] = 6'h0A; data_wr[1] = 32'h66; wr_en = 2'b11;
    tick(); wr_en = '0; addr[0] = 6'h20; addr[1] = 6'h0A; #1;
`ifdef RAM_PARTITION_GATING_EN
    exp_gated = 32'd0; exp_ungated = 32'hA5A5A5A5;
`else
    exp_gated = 32'h55; exp_ungated = 32'h55;
`endif
    check("gated_part_read", rd_z[0], exp_gated);
    check("part0_write", rd_z[1], 32'h66);
    pg = '0; #1;
    check("ungated_retained", rd_z[0], exp_ungated);

    // Random traffic on entries 0..15 against a golden model
    for (int k = 0; k < 16; k++) mdl[k] = 32'd0;
    mdl[3] = 32'hDEADBEEF; mdl[7] = 32'h44; mdl[10] = 32'h66;
    for (int c = 0; c < 2000; c++) begin
      err_before = errors;
      for (int i = 0; i < 4; i++) addr[i] = 6'($urandom_range(15));
      for (int w = 0; w < 2; w++) begin
        addr_wr[w] = 6'($urandom_range(15));
        data_wr[w] = 32'($urandom);
      end
      wr_en = 2'($urandom_range(3));
      wpg   = 2'($urandom_range(3));
      rpg   = 4'($urandom_range(15));
      #1;
      for (int i = 0; i < 4; i++)
        check("rand_rd", rd_z[i], rpg[i] ? 32'd0 : mdl[addr[i][3:0]]);
      if (errors != err_before) break;
      for (int w = 0; w < 2; w++)
        if (wr_en[w] && !wpg[w]) mdl[addr_wr[w][3:0]] = data_wr[w];
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
